// File: rtl/fma16_pkg.sv
// Shared types for the fma16 issue queue: opcodes, rounding modes, decoded
// controls, the result FIFO entry and the opcode decoder.
// FMA16_ISSUE_TAG_EN adds a 4-bit tag to each result entry.
package fma16_pkg;

   typedef enum logic [2:0] {
      OP_FADD    = 3'b000,
      OP_FSUB    = 3'b001,
      OP_FMUL    = 3'b010,
      OP_FMADD   = 3'b011,
      OP_FMSUB   = 3'b100,
      OP_FNMADD  = 3'b101,
      OP_FNMSUB  = 3'b110,
      OP_ILLEGAL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RP  = 2'b10,
      RM_RN  = 2'b11
   } rm_e;

   typedef struct packed {
      logic mul;
      logic add;
      logic negr;
      logic negz;
      rm_e  rm;
   } fma_ctl_t;

   // One buffered result; illegal ops carry the canonical quiet NaN.
   typedef struct packed {
`ifdef FMA16_ISSUE_TAG_EN
      logic [3:0]  tag;
`endif
      logic        illegal;
      logic [15:0] result;
   } res_ent_t;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   // Rounding mode is left at RZ; the caller overlays the requested mode.
   function automatic fma_ctl_t decode_op(op_e op);
      fma_ctl_t c;
      c    = '0;
      c.rm = RM_RZ;
      case (op)
         OP_FADD:   {c.mul, c.add, c.negr, c.negz} = 4'b0100;
         OP_FSUB:   {c.mul, c.add, c.negr, c.negz} = 4'b0101;
         OP_FMUL:   {c.mul, c.add, c.negr, c.negz} = 4'b1000;
         OP_FMADD:  {c.mul, c.add, c.negr, c.negz} = 4'b1100;
         OP_FMSUB:  {c.mul, c.add, c.negr, c.negz} = 4'b1101;
         OP_FNMADD: {c.mul, c.add, c.negr, c.negz} = 4'b1110;
         OP_FNMSUB: {c.mul, c.add, c.negr, c.negz} = 4'b1111;
         default:   {c.mul, c.add, c.negr, c.negz} = 4'b0000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fma16_issue_queue_if.sv
// Command and result handshakes of the fma16 issue queue.
// master = command producer / result consumer, slave = the queue.
// FMA16_ISSUE_TAG_EN adds in_tag/out_tag.
interface fma16_issue_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [15:0] in_z;
   logic [1:0]  in_rm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_illegal;
`ifdef FMA16_ISSUE_TAG_EN
   logic [3:0]  in_tag;
   logic [3:0]  out_tag;
`endif

   modport master (
      output in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
      input  in_ready, out_valid, out_result, out_illegal
`ifdef FMA16_ISSUE_TAG_EN
      , output in_tag
      , input  out_tag
`endif
   );

   modport slave (
      input  in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
      output in_ready, out_valid, out_result, out_illegal
`ifdef FMA16_ISSUE_TAG_EN
      , input  in_tag
      , output out_tag
`endif
   );
endinterface

// File: rtl/fma16_result_fifo.sv
// In-order result buffer. The head is held in a register so that it keeps
// its last value while the FIFO is empty.
module fma16_result_fifo
   import fma16_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  res_ent_t                 wr_ent,
   input  logic                     pop,
   output res_ent_t                 head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   res_ent_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]          cnt_q, cnt_d, cnt_after_pop;
   res_ent_t             head_q, head_d;

   // Pointer/occupancy update and next head selection.
   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      head_d = head_q;
      if (push) begin
         mem_d[wr_q] = wr_ent;
         wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_after_pop = cnt_q - (AW+1)'(pop);
      cnt_d         = cnt_after_pop + (AW+1)'(push);
      // A write into an otherwise empty FIFO becomes the head directly.
      if (push && cnt_after_pop == '0) head_d = wr_ent;
      else if (cnt_after_pop != '0)    head_d = mem_q[rd_d];
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   assign head  = head_q;
   assign count = cnt_q;
endmodule

// File: rtl/fma16_issue_queue.sv
// Issue/return sequencer around fma16: decodes commands into fma16 controls,
// tracks ops in flight for LAT cycles, and buffers results in order. Credits
// (FIFO occupancy + ops in flight) gate acceptance so no result is dropped.
// FMA16_ISSUE_TAG_EN carries a 4-bit tag alongside each op.
module fma16_issue_queue
   import fma16_pkg::*;
#(
   parameter int LAT   = 1,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   fma16_issue_queue_if.slave io,
   output logic [15:0]        fma_x,
   output logic [15:0]        fma_y,
   output logic [15:0]        fma_z,
   output logic               fma_mul,
   output logic               fma_add,
   output logic               fma_negr,
   output logic               fma_negz,
   output logic [1:0]         fma_rm,
   input  logic [15:0]        fma_result
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 2;

   logic           accept, push, pop;
   logic [15:0]    x_q, x_d, y_q, y_d, z_q, z_d;
   fma_ctl_t       ctl_q, ctl_d;
   logic [LAT-1:0] pend_vld_q, pend_vld_d, pend_ill_q, pend_ill_d;
`ifdef FMA16_ISSUE_TAG_EN
   logic [LAT-1:0][3:0] pend_tag_q, pend_tag_d;
`endif
   logic [CW-1:0]  used;
   logic [AW:0]    fifo_cnt;
   res_ent_t       wr_ent, head;

   // Credits come only from registered state, so a pop never opens
   // in_ready in the same cycle.
   always_comb begin
      used = CW'(fifo_cnt);
      for (int i = 0; i < LAT; i++) used = used + CW'(pend_vld_q[i]);
      io.in_ready = !reset && (used < CW'(DEPTH));
   end

   assign accept = io.in_valid && io.in_ready;
   assign pop    = io.out_valid && io.out_ready;

   // Issue registers load on accept and otherwise hold.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      z_d   = z_q;
      ctl_d = ctl_q;
      if (accept) begin
         x_d      = io.in_x;
         y_d      = io.in_y;
         z_d      = io.in_z;
         ctl_d    = decode_op(op_e'(io.in_op));
         ctl_d.rm = rm_e'(io.in_rm);
      end
   end

   // Pending pipe shifts every cycle; its tail selects the FIFO write.
   always_comb begin
      pend_vld_d[0] = accept;
      pend_ill_d[0] = accept && (io.in_op == OP_ILLEGAL);
`ifdef FMA16_ISSUE_TAG_EN
      pend_tag_d[0] = io.in_tag;
`endif
      for (int i = 1; i < LAT; i++) begin
         pend_vld_d[i] = pend_vld_q[i-1];
         pend_ill_d[i] = pend_ill_q[i-1];
`ifdef FMA16_ISSUE_TAG_EN
         pend_tag_d[i] = pend_tag_q[i-1];
`endif
      end
      push           = pend_vld_q[LAT-1];
      wr_ent         = '0;
      wr_ent.illegal = pend_ill_q[LAT-1];
      wr_ent.result  = pend_ill_q[LAT-1] ? FP16_QNAN : fma_result;
`ifdef FMA16_ISSUE_TAG_EN
      wr_ent.tag     = pend_tag_q[LAT-1];
`endif
   end

   // Issue and pending-pipe registers; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         ctl_q      <= '0;
         pend_vld_q <= '0;
         pend_ill_q <= '0;
`ifdef FMA16_ISSUE_TAG_EN
         pend_tag_q <= '0;
`endif
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         ctl_q      <= ctl_d;
         pend_vld_q <= pend_vld_d;
         pend_ill_q <= pend_ill_d;
`ifdef FMA16_ISSUE_TAG_EN
         pend_tag_q <= pend_tag_d;
`endif
      end
   end

   fma16_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .wr_ent (wr_ent),
      .pop    (pop),
      .head   (head),
      .count  (fifo_cnt)
   );

   assign fma_x          = x_q;
   assign fma_y          = y_q;
   assign fma_z          = z_q;
   assign fma_mul        = ctl_q.mul;
   assign fma_add        = ctl_q.add;
   assign fma_negr       = ctl_q.negr;
   assign fma_negz       = ctl_q.negz;
   assign fma_rm         = ctl_q.rm;
   assign io.out_valid   = (fifo_cnt != '0);
   assign io.out_result  = head.result;
   assign io.out_illegal = head.illegal;
`ifdef FMA16_ISSUE_TAG_EN
   assign io.out_tag     = head.tag;
`endif
endmodule

// File: tb/tb_fma16_issue_queue.sv
// Directed bench for fma16_issue_queue: dut_a (LAT=1, DEPTH=4) and
// dut_b (LAT=3, DEPTH=2), each fed by a stand-in fma16 model.
module tb_fma16_issue_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   fma16_issue_queue_if ia();
   fma16_issue_queue_if ib();

   logic [15:0] fa_x, fa_y, fa_z, fa_res, fb_x, fb_y, fb_z, fb_res;
   logic        fa_mul, fa_add, fa_negr, fa_negz, fb_mul, fb_add, fb_negr, fb_negz;
   logic [1:0]  fa_rm, fb_rm;
   logic [15:0] fb_r1 = '0, fb_r2 = '0;

   // Stand-in fma16: returns 4200 for 1.0*2.0+1.0 fmadd, a bit mix otherwise.
   function automatic logic [15:0] mock(input logic [15:0] x, y, z, input logic [3:0] c);
      if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && c == 4'b1100) return 16'h4200;
      return x ^ {y[6:0], y[15:7]} ^ ~z ^ {12'h000, c};
   endfunction

   // {mul, add, negr, negz} per opcode.
   function automatic logic [3:0] exp_ctl(input logic [2:0] op);
      case (op)
         3'd0: return 4'b0100;
         3'd1: return 4'b0101;
         3'd2: return 4'b1000;
         3'd3: return 4'b1100;
         3'd4: return 4'b1101;
         3'd5: return 4'b1110;
         3'd6: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [16:0] exp_res(input logic [2:0] op, input logic [15:0] x, y, z);
      if (op == 3'd7) return {1'b1, 16'h7E00};
      return {1'b0, mock(x, y, z, exp_ctl(op))};
   endfunction

   assign fa_res = mock(fa_x, fa_y, fa_z, {fa_mul, fa_add, fa_negr, fa_negz});
   always @(posedge clk) begin
      fb_r1 <= mock(fb_x, fb_y, fb_z, {fb_mul, fb_add, fb_negr, fb_negz});
      fb_r2 <= fb_r1;
   end
   assign fb_res = fb_r2;

   fma16_issue_queue #(.LAT(1), .DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .io(ia),
      .fma_x(fa_x), .fma_y(fa_y), .fma_z(fa_z),
      .fma_mul(fa_mul), .fma_add(fa_add), .fma_negr(fa_negr), .fma_negz(fa_negz),
      .fma_rm(fa_rm), .fma_result(fa_res)
   );

   fma16_issue_queue #(.LAT(3), .DEPTH(2)) dut_b (
      .clk(clk), .reset(reset), .io(ib),
      .fma_x(fb_x), .fma_y(fb_y), .fma_z(fb_z),
      .fma_mul(fb_mul), .fma_add(fb_add), .fma_negr(fb_negr), .fma_negz(fb_negz),
      .fma_rm(fb_rm), .fma_result(fb_res)
   );

   int n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0, pops = 0;
   int first_pop = -1, last_pop = 0, stale = 0;
   logic acc;
   logic [16:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] x, y, z, input logic [1:0] rm);
      ia.in_valid = 1'b1;
      ia.in_op    = op;
      ia.in_x     = x;
      ia.in_y     = y;
      ia.in_z     = z;
      ia.in_rm    = rm;
   endtask

   // Evaluate handshakes of dut_a for the coming edge, then advance a cycle.
   task automatic tick();
      logic [16:0] e;
      acc = ia.in_valid && ia.in_ready;
      if (acc) begin
         sb_q.push_back(exp_res(ia.in_op, ia.in_x, ia.in_y, ia.in_z));
         n_acc++;
      end
      if (ia.out_valid && ia.out_ready) begin
         e = 17'h1FFFF;
         if (sb_q.size() != 0) e = sb_q.pop_front();
         chk("out_head", {15'h0, ia.out_illegal, ia.out_result}, {15'h0, e});
         pops++;
         last_pop = cyc;
         if (first_pop < 0) first_pop = cyc;
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      ia.in_valid = 0; ia.in_op = 0; ia.in_x = 0; ia.in_y = 0; ia.in_z = 0; ia.in_rm = 0;
      ia.out_ready = 0;
      ib.in_valid = 0; ib.in_op = 0; ib.in_x = 0; ib.in_y = 0; ib.in_z = 0; ib.in_rm = 0;
      ib.out_ready = 0;
`ifdef FMA16_ISSUE_TAG_EN
      ia.in_tag = 0;
      ib.in_tag = 0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", ia.in_ready, 0);
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_out_result", ia.out_result, 0);
      chk("rst_out_illegal", ia.out_illegal, 0);
      chk("rst_fma_x", fa_x, 0);
      chk("rst_fma_ctl", {fa_mul, fa_add, fa_negr, fa_negz, fa_rm}, 0);
      chk("rst_b_in_ready", ib.in_ready, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_ready", ia.in_ready, 1);

      // fmadd 1.0*2.0+1.0, rne
      ia.out_ready = 1'b1;
      drive(3'd3, 16'h3C00, 16'h4000, 16'h3C00, 2'b01);
      tick();
      chk("fmadd_acc", acc, 1);
      ia.in_valid = 1'b0;
      chk("fmadd_ctl", {fa_mul, fa_add, fa_negr, fa_negz}, 4'b1100);
      chk("fmadd_rm", fa_rm, 2'b01);
      chk("fmadd_x", fa_x, 16'h3C00);
      chk("fmadd_early_ov", ia.out_valid, 0);
      tick();
      chk("fmadd_ov", ia.out_valid, 1);
      chk("fmadd_res", ia.out_result, 16'h4200);
      tick();

      // illegal opcode
      drive(3'd7, 16'h1234, 16'h5678, 16'h9ABC, 2'b10);
      tick();
      chk("ill_acc", acc, 1);
      ia.in_valid = 1'b0;
      chk("ill_ctl", {fa_mul, fa_add, fa_negr, fa_negz}, 0);
      tick();
      chk("ill_res", ia.out_result, 16'h7E00);
      chk("ill_flag", ia.out_illegal, 1);
      tick();
      chk("empty_ov", ia.out_valid, 0);
      chk("empty_hold_res", ia.out_result, 16'h7E00);
      chk("empty_hold_ill", ia.out_illegal, 1);

      // back-to-back decode sweep
      for (int i = 0; i < 7; i++) begin
         drive(3'(i), 16'(16'h1000 + i * 16'h0111), 16'(16'h3C00 ^ i), 16'(16'h0400 + i), 2'(i));
         tick();
         chk($sformatf("sweep_acc%0d", i), acc, 1);
         chk($sformatf("dec_op%0d", i), {fa_mul, fa_add, fa_negr, fa_negz}, exp_ctl(3'(i)));
      end
      ia.in_valid = 1'b0;
      repeat (3) tick();
      chk("sweep_drained", sb_q.size(), 0);

      // backpressure: 8 fmul offered with out_ready low
      ia.out_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         drive(3'd2, 16'(16'h4000 + i), 16'(16'h3800 + i), 16'h0000, 2'b01);
         tick();
      end
      ia.in_valid = 1'b0;
      chk("bp_accepted", n_acc, 4);
      chk("bp_in_ready", ia.in_ready, 0);
      chk("bp_out_valid", ia.out_valid, 1);
      ia.out_ready = 1'b1;
      #1;
      chk("bp_no_comb_ready", ia.in_ready, 0);
      tick();
      chk("bp_reopen", ia.in_ready, 1);
      repeat (5) tick();
      chk("bp_drained", sb_q.size(), 0);

      // steady stream of 20 ops
      n_acc = 0; pops = 0; first_pop = -1;
      for (int i = 0; i < 20; i++) begin
         drive(3'(i % 7), 16'(i * 16'h0123), 16'(16'hABCD - i), 16'(i << 4), 2'(i));
         tick();
      end
      ia.in_valid = 1'b0;
      repeat (4) tick();
      chk("stream_acc", n_acc, 20);
      chk("stream_pops", pops, 20);
      chk("stream_no_gaps", last_pop - first_pop, 19);

      // reset with 3 ops in flight
      ia.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(3'd0, 16'(16'h2000 + i), 16'h2400, 16'h0000, 2'b00);
         tick();
      end
      ia.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst2_in_ready", ia.in_ready, 0);
      tick();
      chk("rst2_out_valid", ia.out_valid, 0);
      chk("rst2_in_ready_hold", ia.in_ready, 0);
      reset = 1'b0;
      sb_q.delete();
      ia.out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         if (ia.out_valid) stale++;
         tick();
      end
      chk("rst2_stale", stale, 0);
      drive(3'd2, 16'h3C00, 16'h3C00, 16'h0000, 2'b01);
      tick();
      chk("post_rst_acc", acc, 1);
      ia.in_valid = 1'b0;
      tick();
      chk("post_rst_ov", ia.out_valid, 1);
      tick();
      chk("post_rst_drained", sb_q.size(), 0);

      // dut_b: LAT=3, DEPTH=2
      ib.out_ready = 1'b1;
      ib.in_valid = 1'b1; ib.in_op = 3'd2; ib.in_rm = 2'b01;
      ib.in_x = 16'h4100; ib.in_y = 16'h4200; ib.in_z = 16'h0000;
      chk("b_ready0", ib.in_ready, 1);
      @(negedge clk);
      chk("b_ready1", ib.in_ready, 1);
      chk("b_fma_x", fb_x, 16'h4100);
      ib.in_x = 16'h4500; ib.in_y = 16'h4600;
      @(negedge clk);
      chk("b_credit_full", ib.in_ready, 0);
      chk("b_ov_k1", ib.out_valid, 0);
      ib.in_valid = 1'b0;
      @(negedge clk);
      chk("b_ov_k2", ib.out_valid, 0);
      @(negedge clk);
      chk("b_ov_k3", ib.out_valid, 1);
      chk("b_res_a", ib.out_result, mock(16'h4100, 16'h4200, 16'h0000, 4'b1000));
      chk("b_ready_k3", ib.in_ready, 0);
      @(negedge clk);
      chk("b_ov_k4", ib.out_valid, 1);
      chk("b_res_b", ib.out_result, mock(16'h4500, 16'h4600, 16'h0000, 4'b1000));
      chk("b_ready_k4", ib.in_ready, 1);
      @(negedge clk);
      chk("b_ov_end", ib.out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fma16_issue_queue.md
Name: fma16_issue_queue

Overview:
- Sequencing stage directly upstream and downstream of fma16: accepts FP16 op commands over a valid/ready handshake and decodes a 3-bit opcode into fma16 controls (mul, add, negr, negz, roundmode).
- Drives registered operands into fma16, captures its result a fixed LAT cycles later, and buffers results in an in-order FIFO with its own valid/ready handshake.
- Credit-based flow control ensures no result is ever dropped.

Parameters:
- LAT, 1, cycles from issue-register load to fma_result being sampled; legal range 1..4.
- DEPTH, 4, result FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at a clk edge.
- in_op  input  3  opcode: 000 fadd, 001 fsub, 010 fmul, 011 fmadd, 100 fmsub, 101 fnmadd, 110 fnmsub, 111 illegal.
- in_x, in_y, in_z  input  16 each  FP16 operands.
- in_rm  input  2  rounding mode: 00 rz, 01 rne, 10 rp, 11 rn.
- fma_x, fma_y, fma_z  output  16 each  registered operands to fma16.
- fma_mul, fma_add, fma_negr, fma_negz  output  1 each  registered decoded controls.
- fma_rm  output  2  registered rounding mode.
- fma_result  input  16  result from fma16.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head on out_valid & out_ready.
- out_result  output  16  FIFO head result.
- out_illegal  output  1  head came from opcode 111.

Behaviour:
- Reset values: in_ready=0 during the reset cycle; out_valid=0; out_result=0; out_illegal=0; all fma_* outputs 0.
- Reset state: FIFO empty, credit count 0, pending-valid pipe cleared.
- Reset mid-operation: discards all in-flight and buffered results. No partial output is ever produced.
- Decode table (mul, add, negr, negz):
  - fadd 0,1,0,0
  - fsub 0,1,0,1
  - fmul 1,0,0,0
  - fmadd 1,1,0,0
  - fmsub 1,1,0,1
  - fnmadd 1,1,1,0
  - fnmsub 1,1,1,1
  - illegal 0,0,0,0
- Issue: on accept at edge k, operands, controls and rm load into the issue registers. Issue registers hold their value until the next accept; they are not cleared when idle.
- Pending pipe: a LAT-deep shift register of {valid, illegal} bits, shifted every cycle.
  - At edge k+LAT the entry reaches the tail, fma_result is sampled and written to the FIFO.
  - For an illegal entry, the written value is 16'h7E00 with illegal flag=1, regardless of fma_result.
- Latency: accept at edge k; out_valid=1 in the cycle after edge k+LAT if the FIFO was empty. Throughput is one op per cycle.
- Credits: used = FIFO occupancy + pending count.
  - in_ready = !reset && (used < DEPTH).
  - A pop in the same cycle does not raise in_ready combinationally; there is no ready-to-ready path.
- Simultaneous push and pop: occupancy unchanged; head advances in order.
- FIFO full with out_ready=0: in_ready=0 and no pending entry exists. A stalled output never loses data.
- FIFO empty: out_valid=0. out_result and out_illegal hold their last value and are not re-driven by a write in the same cycle.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH; occupancy is log2(DEPTH)+1 bits.

Optional Feature:
- FMA16_ISSUE_TAG_EN defined: adds ports in_tag (input, 4) and out_tag (output, 4).
  - The tag travels with the pending pipe and the FIFO entry; out_tag reset value is 0.
- Undefined: no tag ports and no tag storage; behaviour is otherwise identical.

Decomposition:
- Shared package fma16_pkg holds:
  - typedef op_e (3-bit opcode enum, values above) and typedef rm_e (2-bit rounding modes);
  - struct fma_ctl_t {mul, add, negr, negz, rm};
  - constant FP16_QNAN = 16'h7E00;
  - function decode_op(op_e) returning fma_ctl_t.
- One natural sub-module, fma16_result_fifo: DEPTH-parameterised synchronous FIFO carrying {result, illegal[, tag]}, exposing count for the credit logic.

Test Plan:
- fmadd, x=3C00, y=4000, z=3C00, rm=01, LAT=1, out_ready=1: fma_mul=1, fma_add=1, negr=0, negz=0 one cycle after accept; out_result equals the value fma16 drives (4200 with the golden model), out_valid two cycles after accept.
- Opcode 111 with any operands: out_result=7E00, out_illegal=1, and fma_mul=fma_add=0 during its issue cycle.
- out_ready=0 with 8 back-to-back fmul (DEPTH=4): exactly 4 accepted, then in_ready=0. Raising out_ready drains them in order and re-opens in_ready the following cycle.
- Steady stream with out_ready=1 for 20 ops: one accept per cycle, results in order, no gaps after the initial latency.
- Reset asserted for 1 cycle with 3 ops in flight: out_valid=0 and in_ready=0 during reset; no stale results appear afterwards; the next op completes normally.
- LAT=3, DEPTH=2: in_ready drops once 2 ops are pending even with the FIFO empty; the result for the op accepted at edge k appears in the cycle after edge k+3.
